// File: rtl/keccak_avst_arb.sv
// keccak_avst_arb: shares one keccak_avst core between two byte-stream
// requesters. The owner's message is forwarded to the core, and the core's
// digest is routed back to the same owner. After the digest, an optional
// idle gap of IDLE_GAP cycles is inserted before the next grant.
// Build option: define KECCAK_ARB_FIXED_PRIO_EN to select fixed priority,
// with requester 0 winning ties. The default build uses round-robin.
//
// state | meaning
// IDLE  | no owner; a pending request is granted on the next edge
// FWD   | owner's message beats are passed through to the core input
// RESP  | core digest beats are passed through to the owner
// GAP   | digest done; hold off new grants for IDLE_GAP cycles
module keccak_avst_arb #(
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] r0_data_in,
    input  logic       r0_end_in,
    input  logic       r0_valid_in,
    output logic       r0_ready_in,
    output logic [7:0] r0_data_out,
    output logic       r0_valid_out,
    output logic       r0_end_out,
    input  logic       r0_ready_out,
    input  logic [7:0] r1_data_in,
    input  logic       r1_end_in,
    input  logic       r1_valid_in,
    output logic       r1_ready_in,
    output logic [7:0] r1_data_out,
    output logic       r1_valid_out,
    output logic       r1_end_out,
    input  logic       r1_ready_out,
    output logic [7:0] k_data_in,
    output logic       k_end_in,
    output logic       k_valid_in,
    input  logic       k_ready_in,
    input  logic [7:0] k_data_out,
    input  logic       k_valid_out,
    input  logic       k_end_out,
    output logic       k_ready_out,
    output logic       k_reset,
    output logic [1:0] grant,
    output logic       stray_out
);
    typedef enum logic [1:0] {IDLE, FWD, RESP, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       stray_q;
    logic       pick;
    logic       any_req;
    logic       own_valid_in, own_end_in, own_ready_out;
    logic       fwd_act, resp_act;
`ifndef KECCAK_ARB_FIXED_PRIO_EN
    logic       last_q;
`endif

    assign any_req       = r0_valid_in || r1_valid_in;
    assign own_valid_in  = owner_q ? r1_valid_in  : r0_valid_in;
    assign own_end_in    = owner_q ? r1_end_in    : r0_end_in;
    assign own_ready_out = owner_q ? r1_ready_out : r0_ready_out;
    // Reset is synchronous, so the data paths are gated with it directly.
    // This keeps the handshakes quiet during the reset cycle itself.
    assign fwd_act   = (state_q == FWD)  && !reset;
    assign resp_act  = (state_q == RESP) && !reset;
    assign k_reset   = reset;
    assign stray_out = stray_q;
    assign grant     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

    // Choose the next owner from the pending requests.
    always_comb begin
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        pick = ~r0_valid_in;
`else
        if (r0_valid_in && r1_valid_in) begin
            pick = ~last_q;
        end else begin
            pick = ~r0_valid_in;
        end
`endif
    end

    // Steer the message and digest streams between the owner and the core.
    always_comb begin
        k_data_in    = 8'h00;
        k_end_in     = 1'b0;
        k_valid_in   = 1'b0;
        r0_ready_in  = 1'b0;
        r1_ready_in  = 1'b0;
        r0_data_out  = 8'h00;
        r0_valid_out = 1'b0;
        r0_end_out   = 1'b0;
        r1_data_out  = 8'h00;
        r1_valid_out = 1'b0;
        r1_end_out   = 1'b0;
        k_ready_out  = 1'b1;
        if (fwd_act) begin
            k_data_in   = owner_q ? r1_data_in : r0_data_in;
            k_end_in    = own_end_in;
            k_valid_in  = own_valid_in;
            r0_ready_in = !owner_q && k_ready_in;
            r1_ready_in = owner_q && k_ready_in;
        end
        if (resp_act) begin
            k_ready_out = own_ready_out;
            if (owner_q) begin
                r1_data_out  = k_data_out;
                r1_valid_out = k_valid_out;
                r1_end_out   = k_end_out;
            end else begin
                r0_data_out  = k_data_out;
                r0_valid_out = k_valid_out;
                r0_end_out   = k_end_out;
            end
        end
    end

    // Next-state logic, owner selection and gap down-counter.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = FWD;
                    owner_d = pick;
                end
            end
            FWD: begin
                if (own_valid_in && k_ready_in && own_end_in) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (k_valid_out && own_ready_out && k_end_out) begin
                    if (IDLE_GAP > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, owner and gap counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            gap_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifndef KECCAK_ARB_FIXED_PRIO_EN
    // Round-robin pointer. It remembers the last requester granted, and its
    // reset value of 1 gives requester 0 the first turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= pick;
        end
    end
`endif

    // Sticky flag for core output that arrives while no digest is expected.
    always_ff @(posedge clk) begin
        if (reset) begin
            stray_q <= 1'b0;
        end else if (state_q != RESP && k_valid_out) begin
            stray_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_keccak_avst_arb.sv
// Self-checking bench for keccak_avst_arb. A behavioural core answers each
// message with a digest derived from the byte sum and length. Expected
// digests are queued per requester when the requester's message completes.
// A second instance with IDLE_GAP=0 shares the stimulus, and is used only to
// measure back-to-back latency with no gap.
module tb_keccak_avst_arb;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r0_data_in, r1_data_in;
    logic       r0_end_in, r1_end_in, r0_valid_in, r1_valid_in;
    logic       r0_ready_in, r1_ready_in;
    logic [7:0] r0_data_out, r1_data_out;
    logic       r0_valid_out, r1_valid_out, r0_end_out, r1_end_out;
    logic       r0_ready_out, r1_ready_out;
    logic [7:0] k_data_in;
    logic       k_end_in, k_valid_in, k_ready_in;
    logic [7:0] k_data_out;
    logic       k_valid_out, k_end_out, k_ready_out;
    logic       k_reset, stray_out;
    logic [1:0] grant;

    logic       g0_r0_ready_in, g0_r1_ready_in;
    logic [7:0] g0_r0_data_out, g0_r1_data_out, g0_k_data_in;
    logic       g0_r0_valid_out, g0_r1_valid_out, g0_r0_end_out, g0_r1_end_out;
    logic       g0_k_end_in, g0_k_valid_in, g0_k_ready_out, g0_k_reset, g0_stray_out;
    logic [1:0] g0_grant;

    keccak_avst_arb #(.IDLE_GAP(3)) dut (
        .clk(clk), .reset(reset),
        .r0_data_in(r0_data_in), .r0_end_in(r0_end_in), .r0_valid_in(r0_valid_in),
        .r0_ready_in(r0_ready_in), .r0_data_out(r0_data_out), .r0_valid_out(r0_valid_out),
        .r0_end_out(r0_end_out), .r0_ready_out(r0_ready_out),
        .r1_data_in(r1_data_in), .r1_end_in(r1_end_in), .r1_valid_in(r1_valid_in),
        .r1_ready_in(r1_ready_in), .r1_data_out(r1_data_out), .r1_valid_out(r1_valid_out),
        .r1_end_out(r1_end_out), .r1_ready_out(r1_ready_out),
        .k_data_in(k_data_in), .k_end_in(k_end_in), .k_valid_in(k_valid_in),
        .k_ready_in(k_ready_in), .k_data_out(k_data_out), .k_valid_out(k_valid_out),
        .k_end_out(k_end_out), .k_ready_out(k_ready_out),
        .k_reset(k_reset), .grant(grant), .stray_out(stray_out)
    );

    keccak_avst_arb #(.IDLE_GAP(0)) dut_g0 (
        .clk(clk), .reset(reset),
        .r0_data_in(r0_data_in), .r0_end_in(r0_end_in), .r0_valid_in(r0_valid_in),
        .r0_ready_in(g0_r0_ready_in), .r0_data_out(g0_r0_data_out), .r0_valid_out(g0_r0_valid_out),
        .r0_end_out(g0_r0_end_out), .r0_ready_out(r0_ready_out),
        .r1_data_in(r1_data_in), .r1_end_in(r1_end_in), .r1_valid_in(r1_valid_in),
        .r1_ready_in(g0_r1_ready_in), .r1_data_out(g0_r1_data_out), .r1_valid_out(g0_r1_valid_out),
        .r1_end_out(g0_r1_end_out), .r1_ready_out(r1_ready_out),
        .k_data_in(g0_k_data_in), .k_end_in(g0_k_end_in), .k_valid_in(g0_k_valid_in),
        .k_ready_in(k_ready_in), .k_data_out(k_data_out), .k_valid_out(k_valid_out),
        .k_end_out(k_end_out), .k_ready_out(g0_k_ready_out),
        .k_reset(g0_k_reset), .grant(g0_grant), .stray_out(g0_stray_out)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         dlen = 32;
    bit         kin_tog = 1'b0;
    bit         inj_valid = 1'b0;
    logic [8:0] expq0[$];
    logic [8:0] expq1[$];
    int         order[$];
    int         rcv[2];
    int         end_cyc[2];
    int         first_acc[2];
    int         g0_first = -1;
    bit         g0_arm = 1'b0;
    logic [1:0] seen_grant = 2'b00;

    typedef struct {
        int         req;
        int         len;
        logic [7:0] seed;
        bit         kin_tog;
        int         stall_at;
        int         dlen;
        logic [1:0] exp_grant;
    } vec_t;
    vec_t vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dig_byte(input logic [7:0] sum, input int len, input int i);
        return sum + 8'(len * 17) + 8'(i * 5) + 8'h3C;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_req(input int n, input logic v, input logic [7:0] d, input logic e);
        if (n == 0) begin
            r0_valid_in = v; r0_data_in = d; r0_end_in = e;
        end else begin
            r1_valid_in = v; r1_data_in = d; r1_end_in = e;
        end
    endtask

    task automatic set_rdy(input int n, input logic v);
        if (n == 0) r0_ready_out = v;
        else r1_ready_out = v;
    endtask

    // Send one message. Bytes are seed+i, and the last byte carries end. When
    // the message completes, the expected digest is queued.
    task automatic send_msg(input int n, input int len, input logic [7:0] seed);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        logic       rdy;
        int         i = 0;
        int         guard = 0;
        while (i < len && guard < 3000) begin
            @(negedge clk);
            b = seed + 8'(i);
            drive_req(n, 1'b1, b, (i == len - 1));
            #1;
            rdy = (n == 0) ? r0_ready_in : r1_ready_in;
            if (rdy) begin
                if (i == 0) first_acc[n] = cyc;
                sum = sum + b;
                i++;
            end
            guard++;
        end
        checks++;
        if (i < len) begin
            errors++;
            $display("FAIL send r%0d timeout: accepted %0d of %0d beats", n, i, len);
        end else begin
            for (int j = 0; j < dlen; j++) begin
                if (n == 0) expq0.push_back({(j == dlen - 1), dig_byte(sum, len, j)});
                else        expq1.push_back({(j == dlen - 1), dig_byte(sum, len, j)});
            end
        end
        @(posedge clk);
        #1;
        drive_req(n, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic stall_out(input int n, input int at);
        int g = 0;
        if (at < 0) return;
        while (rcv[n] < at && g < 2000) begin
            @(negedge clk);
            g++;
        end
        set_rdy(n, 1'b0);
        repeat (3) @(negedge clk);
        set_rdy(n, 1'b1);
    endtask

    task automatic wait_rcv(input int n, input int target, input int budget);
        int g = 0;
        while (rcv[n] < target && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("wait r%0d digest bytes", n), (rcv[n] >= target) ? target : rcv[n], target);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset = 1'b1;
        drive_req(0, 1'b0, 8'h00, 1'b0);
        drive_req(1, 1'b0, 8'h00, 1'b0);
        r0_ready_out = 1'b1;
        r1_ready_out = 1'b1;
        repeat (ncyc) @(negedge clk);
        reset = 1'b0;
        expq0.delete();
        expq1.delete();
        order.delete();
        rcv[0] = 0; rcv[1] = 0;
        end_cyc[0] = -1; end_cyc[1] = -1;
        first_acc[0] = -1; first_acc[1] = -1;
        seen_grant = 2'b00;
    endtask

    task automatic pop_cmp(input int n, input logic [7:0] d, input logic e);
        logic [8:0] exp;
        checks++;
        if ((n == 0 && expq0.size() == 0) || (n == 1 && expq1.size() == 0)) begin
            errors++;
            $display("FAIL r%0d digest beat: got 0x%0h end=%0b, expected none", n, d, e);
        end else begin
            if (n == 0) exp = expq0.pop_front();
            else        exp = expq1.pop_front();
            if ({e, d} !== exp) begin
                errors++;
                $display("FAIL r%0d digest beat %0d: got end=%0b data=0x%0h, expected end=%0b data=0x%0h",
                         n, rcv[n], e, d, exp[8], exp[7:0]);
            end
        end
        rcv[n]++;
        if (e) begin
            order.push_back(n);
            end_cyc[n] = cyc;
        end
    endtask

    // Behavioural core: sums message bytes, then returns dlen digest bytes.
    logic [7:0] c_sum;
    int         c_cnt, c_idx;
    bit         c_resp;
    initial begin
        k_ready_in = 1'b1; k_valid_out = 1'b0; k_data_out = 8'h00; k_end_out = 1'b0;
        c_sum = 8'h00; c_cnt = 0; c_idx = 0; c_resp = 1'b0;
        forever begin
            @(negedge clk);
            k_ready_in  = kin_tog ? ~k_ready_in : 1'b1;
            k_valid_out = c_resp || inj_valid;
            k_data_out  = c_resp ? dig_byte(c_sum, c_cnt, c_idx) : (inj_valid ? 8'hA5 : 8'h00);
            k_end_out   = c_resp && (c_idx == dlen - 1);
            #1;
            if (k_reset) begin
                c_resp = 1'b0; c_sum = 8'h00; c_cnt = 0; c_idx = 0;
            end else if (c_resp) begin
                if (k_valid_out && k_ready_out) begin
                    if (c_idx == dlen - 1) begin
                        c_resp = 1'b0; c_sum = 8'h00; c_cnt = 0;
                    end else begin
                        c_idx++;
                    end
                end
            end else if (k_valid_in && k_ready_in) begin
                c_sum = c_sum + k_data_in;
                c_cnt++;
                if (k_end_in) begin
                    c_resp = 1'b1;
                    c_idx  = 0;
                end
            end
        end
    end

    // Output monitor: scoreboard pops plus per-cycle invariants.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("k_reset follows reset", int'(k_reset), int'(reset));
            if (!reset) begin
                seen_grant = seen_grant | grant;
                if (grant != 2'b01)
                    chk("r0 quiet when not owner", int'({r0_valid_out, r0_end_out, r0_ready_in, r0_data_out}), 0);
                if (grant != 2'b10)
                    chk("r1 quiet when not owner", int'({r1_valid_out, r1_end_out, r1_ready_in, r1_data_out}), 0);
                if (grant == 2'b00)
                    chk("k_ready_out high in idle", int'(k_ready_out), 1);
                if (r0_valid_out && r0_ready_out) pop_cmp(0, r0_data_out, r0_end_out);
                if (r1_valid_out && r1_ready_out) pop_cmp(1, r1_data_out, r1_end_out);
                if (g0_arm && g0_first < 0 && r1_valid_in && g0_r1_ready_in) g0_first = cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        int hold;
        vecs[0] = '{0, 3, 8'h61, 1'b0, -1, 32, 2'b01};
        vecs[1] = '{1, 5, 8'h10, 1'b1, 10, 32, 2'b10};
        vecs[2] = '{0, 1, 8'hF0, 1'b1, -1,  1, 2'b01};
        vecs[3] = '{1, 8, 8'h33, 1'b0,  0,  4, 2'b10};
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        reset = 1'b1;
        drive_req(0, 1'b1, 8'h55, 1'b0);
        drive_req(1, 1'b1, 8'h66, 1'b0);
        r0_ready_out = 1'b1;
        r1_ready_out = 1'b1;

        // Reset state, with requests present during reset.
        repeat (3) @(negedge clk);
        #1;
        chk("reset k_reset", int'(k_reset), 1);
        chk("reset ready_in", int'({r0_ready_in, r1_ready_in}), 0);
        chk("reset valid/end out", int'({r0_valid_out, r1_valid_out, r0_end_out, r1_end_out}), 0);
        chk("reset k_valid_in", int'(k_valid_in), 0);
        chk("reset grant", int'(grant), 0);
        chk("reset stray", int'(stray_out), 0);
        do_reset(1);
        #1;
        chk("post-reset grant", int'(grant), 0);

        // Table-driven single transactions.
        for (int t = 0; t < 4; t++) begin
            do_reset(2);
            dlen    = vecs[t].dlen;
            kin_tog = vecs[t].kin_tog;
            fork
                send_msg(vecs[t].req, vecs[t].len, vecs[t].seed);
                stall_out(vecs[t].req, vecs[t].stall_at);
            join
            wait_rcv(vecs[t].req, vecs[t].dlen, 500);
            repeat (6) @(negedge clk);
            #1;
            chk($sformatf("vec%0d grants seen", t), int'(seen_grant), int'(vecs[t].exp_grant));
            chk($sformatf("vec%0d digest bytes", t), rcv[vecs[t].req], vecs[t].dlen);
            chk($sformatf("vec%0d other requester bytes", t), rcv[1 - vecs[t].req], 0);
            chk($sformatf("vec%0d grant after", t), int'(grant), 0);
            chk($sformatf("vec%0d queue drained", t),
                (vecs[t].req == 0) ? expq0.size() : expq1.size(), 0);
        end
        kin_tog = 1'b0;

        // Contention: two messages from each requester, requested together.
        do_reset(1);
        dlen = 4;
        fork
            begin send_msg(0, 2, 8'h20); send_msg(0, 3, 8'h40); end
            begin send_msg(1, 2, 8'h60); send_msg(1, 1, 8'h80); end
        join
        hold = 0;
        while (order.size() < 4 && hold < 500) begin
            @(negedge clk);
            hold++;
        end
        chk("contention digests done", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("contention order[%0d]", i), (i < order.size()) ? order[i] : -1, exp_order[i]);

        // Back-to-back latency with r1 waiting at digest end (gap 3 and gap 0).
        do_reset(1);
        dlen     = 6;
        g0_first = -1;
        g0_arm   = 1'b1;
        fork
            send_msg(0, 3, 8'h11);
            send_msg(1, 2, 8'h22);
        join
        wait_rcv(1, 6, 500);
        chk("gap3 first beat latency", first_acc[1] - end_cyc[0], 5);
        chk("gap0 first beat latency", g0_first - end_cyc[0], 2);
        g0_arm = 1'b0;

        // Reset for one cycle after the tenth digest byte.
        do_reset(1);
        dlen = 32;
        send_msg(0, 4, 8'h50);
        wait_rcv(0, 10, 500);
        reset = 1'b1;
        #1;
        chk("mid-digest reset k_reset", int'(k_reset), 1);
        chk("mid-digest reset r0 outputs", int'({r0_valid_out, r0_end_out, r0_ready_in}), 0);
        chk("mid-digest reset k_valid_in", int'(k_valid_in), 0);
        @(negedge clk);
        reset = 1'b0;
        expq0.delete();
        hold = rcv[0];
        #1;
        chk("after reset grant", int'(grant), 0);
        chk("after reset stray", int'(stray_out), 0);
        repeat (30) @(negedge clk);
        #1;
        chk("no r0 output after reset", rcv[0], hold);
        chk("stray still clear", int'(stray_out), 0);

        // Stray core output while idle.
        do_reset(1);
        @(posedge clk);
        #1;
        inj_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("stray not yet set", int'(stray_out), 0);
        chk("stray cycle requester valid", int'({r0_valid_out, r1_valid_out}), 0);
        chk("stray cycle k_ready_out", int'(k_ready_out), 1);
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stray set", int'(stray_out), 1);
        repeat (5) @(negedge clk);
        #1;
        chk("stray sticky", int'(stray_out), 1);
        do_reset(1);
        #1;
        chk("stray cleared by reset", int'(stray_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keccak_avst_arb.md
KECCAK_AVST_ARB -- requirements
Module: keccak_avst_arb

Interface
REQ-001 The block SHALL have one parameter: IDLE_GAP, default 1, number of idle cycles inserted between the end of one digest and the next grant (0..15).
REQ-002 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have ports rN_data_in/rN_end_in/rN_valid_in, input, 8/1/1, requester N (N=0,1) message byte stream.
REQ-005 The block SHALL have port rN_ready_in, output, 1, back-pressure to requester N.
REQ-006 The block SHALL have ports rN_data_out/rN_valid_out/rN_end_out, output, 8/1/1, digest stream to requester N.
REQ-007 The block SHALL have port rN_ready_out, input, 1, requester N digest sink ready.
REQ-008 The block SHALL have ports k_data_in/k_end_in/k_valid_in, output, 8/1/1, and k_ready_in, input, 1, toward the keccak_avst core input.
REQ-009 The block SHALL have ports k_data_out/k_valid_out/k_end_out, input, 8/1/1, and k_ready_out, output, 1, from the core output.
REQ-010 The block SHALL have ports k_reset, output, 1, core reset; grant, output, 2, one-hot owner; stray_out, output, 1, sticky error.

Function
REQ-011 A beat SHALL be accepted on a cycle where valid and ready are both 1; a message ends on the accepted beat with end_in=1.
REQ-012 The FSM SHALL have states IDLE, FWD, RESP, GAP.
REQ-013 In IDLE, when any rN_valid_in=1, the block SHALL register a grant and enter FWD on the next edge; no beat is accepted in the IDLE cycle.
REQ-014 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the pointer updates at grant; after reset requester 0 has priority.
REQ-015 In FWD, k_data_in/k_end_in/k_valid_in SHALL equal the owner's inputs combinationally, and the owner's rN_ready_in SHALL equal k_ready_in.
REQ-016 The non-owner's rN_ready_in SHALL be 0 in every state; both rN_ready_in are 0 outside FWD.
REQ-017 FWD SHALL go to RESP on the edge following an accepted owner beat with end_in=1.
REQ-018 In RESP, the owner's rN_data_out/rN_valid_out/rN_end_out SHALL equal the k_* outputs, and k_ready_out SHALL equal the owner's rN_ready_out.
REQ-019 The non-owner's rN_valid_out and rN_end_out SHALL be 0 in every state, and its rN_data_out SHALL be 0.
REQ-020 RESP SHALL exit on the edge following an accepted beat with k_end_out=1: to GAP if IDLE_GAP>0, else to IDLE.
REQ-021 GAP SHALL last exactly IDLE_GAP cycles, then go to IDLE; requests arriving during GAP are held off (ready_in=0).
REQ-022 Outside RESP, k_ready_out SHALL be 1, core output beats SHALL be discarded, and any k_valid_out=1 SHALL set stray_out until reset.
REQ-023 grant SHALL be 2'b00 in IDLE and one-hot owner in FWD, RESP, GAP.
REQ-024 A requester that deasserts valid mid-message SHALL keep the grant; there is no timeout.
REQ-025 Back-to-back: the earliest first accepted beat of a new message SHALL be IDLE_GAP+2 cycles after the final digest beat.

Reset
REQ-026 Reset SHALL drive FSM to IDLE, grant=0, round-robin pointer to favour requester 0, GAP counter=0, stray_out=0.
REQ-027 k_reset SHALL equal reset combinationally, so a reset mid-message or mid-digest also clears the core.
REQ-028 During reset, all rN_ready_in, rN_valid_out, rN_end_out and k_valid_in SHALL be 0.

Configuration
REQ-029 With KECCAK_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed-priority (requester 0 always wins ties) and the round-robin pointer is removed.
REQ-030 Without KECCAK_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-014.

Verification
REQ-031 Single: r0 sends "abc"+end beat, core returns 32 digest bytes -> all 32 bytes appear on r0 with end on byte 32, r1_valid_out=0 throughout, grant=01 then 00.
REQ-032 Contention: r0,r1 valid in same IDLE cycle after reset -> r0 served first, r1 next; repeated twice -> order r0,r1,r0,r1 (fixed-prio build: r0,r0).
REQ-033 Back-pressure: k_ready_in toggled 1/0 each cycle, rN_ready_out low 3 cycles mid-digest -> no beat lost or duplicated, order preserved.
REQ-034 Gap: IDLE_GAP=3, r1 waiting at digest end -> r1 first accepted beat 5 cycles after final digest beat; IDLE_GAP=0 -> 2 cycles.
REQ-035 Reset mid-RESP: reset held 1 cycle after digest byte 10 -> k_reset=1 that cycle, state IDLE, grant=00, stray_out=0, no further r0 output.
REQ-036 Stray: k_valid_out=1 injected in IDLE -> stray_out=1 next cycle, stays 1 until reset, no requester valid_out.
